execute_pipe: RTL and testbench

Parametrised, registered execute stage for the pipelined core. It performs the ALU operation, resolves branches and jumps, and computes the next PC. Results land in an EX/MEM output register with a valid/ready handshake. It adds an iterative multi-cycle multiply mode that stalls upstream, and a single-cycle redirect/flush output for taken control flow.

---
 rtl/exec_pkg.sv | 29 ++
 rtl/alu.sv | 39 +++
 rtl/mul_seq.sv | 37 +++
 rtl/execute_pipe.sv | 142 ++++++++++++++
 tb/tb_execute_pipe.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/exec_pkg.sv
// Shared encodings for the execute stage: opcode prefixes, operand-source
// selects, ALU operations and the multiply sequencer states.
package exec_pkg;
    localparam int INSTR_W  = 16;
    localparam int IMM5_W   = 5;
    localparam int IMM8_W   = 8;
    localparam int DISP11_W = 11;

    localparam logic [4:0] OP_BEQZ = 5'b01100;
    localparam logic [4:0] OP_BNEZ = 5'b01101;
    localparam logic [4:0] OP_BLTZ = 5'b01110;
    localparam logic [4:0] OP_BGTZ = 5'b01111;
    // XORI / ANDNI share this prefix and take a zero-extended imm5
    localparam logic [3:0] OP_LOGIC_IMM = 4'b0101;

    localparam logic [1:0] SRC_REG  = 2'b00;
    localparam logic [1:0] SRC_IMM5 = 2'b01;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_AND   = 4'd1;
    localparam logic [3:0] ALU_OR    = 4'd2;
    localparam logic [3:0] ALU_XOR   = 4'd3;
    localparam logic [3:0] ALU_SLL   = 4'd4;
    localparam logic [3:0] ALU_SRL   = 4'd5;
    localparam logic [3:0] ALU_SRA   = 4'd6;
    localparam logic [3:0] ALU_PASSA = 4'd7;

    typedef enum logic [1:0] {IDLE, MUL, DONE} ex_state_e;
endpackage

// File: rtl/alu.sv
// Combinational ALU with operand inversion and carry-in; unknown opcodes pass B.
module alu
    import exec_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    input  logic             inv_a,
    input  logic             inv_b,
    input  logic             cin,
    output logic [WIDTH-1:0] r
);
    localparam int SH_W = $clog2(WIDTH);

    logic        [WIDTH-1:0] a_m;
    logic        [WIDTH-1:0] b_m;
    logic signed [WIDTH-1:0] a_s;

    assign a_m = inv_a ? ~a : a;
    assign b_m = inv_b ? ~b : b;
    assign a_s = a_m;

    always_comb begin
        r = b_m;
        case (op)
            ALU_ADD:   r = a_m + b_m + WIDTH'(cin);
            ALU_AND:   r = a_m & b_m;
            ALU_OR:    r = a_m | b_m;
            ALU_XOR:   r = a_m ^ b_m;
            ALU_SLL:   r = a_m << b_m[SH_W-1:0];
            ALU_SRL:   r = a_m >> b_m[SH_W-1:0];
            ALU_SRA:   r = a_s >>> b_m[SH_W-1:0];
            ALU_PASSA: r = a_m;
            default:   r = b_m;
        endcase
    end
endmodule

// File: rtl/mul_seq.sv
// Shift-add multiplier datapath, one multiplier bit per step; keeps the low WIDTH bits.
module mul_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             start,
    input  logic             step,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] product
);
    localparam int CNT_W = $clog2(WIDTH);

    logic [WIDTH-1:0] mcand_p0;
    logic [WIDTH-1:0] mplier_p0;
    logic [WIDTH-1:0] acc_p0;
    logic [CNT_W-1:0] cnt_p0;

    // Datapath only: the controlling FSM owns reset and abort
    always_ff @(posedge clk) begin
        if (start) begin
            mcand_p0  <= a;
            mplier_p0 <= b;
            acc_p0    <= '0;
            cnt_p0    <= '0;
        end else if (step) begin
            acc_p0    <= acc_p0 + (mplier_p0[0] ? mcand_p0 : '0);
            mcand_p0  <= mcand_p0 << 1;
            mplier_p0 <= mplier_p0 >> 1;
            cnt_p0    <= cnt_p0 + CNT_W'(1);
        end
    end

    assign done    = (cnt_p0 == CNT_W'(WIDTH - 1));
    assign product = acc_p0;
endmodule

// File: rtl/execute_pipe.sv
// Execute stage: ALU, branch/jump resolution, next-PC, iterative multiply,
// EX/MEM output register with valid/ready and a one-cycle redirect pulse.
module execute_pipe
    import exec_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter bit MUL_EN = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               flush_in,
    input  logic [INSTR_W-1:0] Instruction,
    input  logic [WIDTH-1:0]   Read1data,
    input  logic [WIDTH-1:0]   Read2data,
    input  logic [WIDTH-1:0]   PC_Inc,
    input  logic [1:0]         ALUSrc_cntrl,
    input  logic [3:0]         ALUOp_cntrl,
    input  logic               ALU_InvA,
    input  logic               ALU_InvB,
    input  logic               ALU_Cin,
    input  logic               Branch_cntrl,
    input  logic               Jump_cntrl,
    input  logic               Mul_cntrl,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   ALU_Out,
    output logic [WIDTH-1:0]   PC_Next,
    output logic               redirect,
    output logic [WIDTH-1:0]   redirect_pc
);
    logic signed [WIDTH-1:0] imm5_s, imm8_s, disp11_s;
    logic [WIDTH-1:0] op_b, alu_r, pc_next, mul_prod, mul_pc_p0;
    logic br_cond, br_taken, ctl_taken, is_mul, accept, out_free;
    logic load_single, load_mul, mul_start, mul_step, mul_done;
    ex_state_e state, state_nx;

    assign imm5_s = (Instruction[15:12] == OP_LOGIC_IMM)
                  ? {{(WIDTH-IMM5_W){1'b0}}, Instruction[IMM5_W-1:0]}
                  : {{(WIDTH-IMM5_W){Instruction[IMM5_W-1]}}, Instruction[IMM5_W-1:0]};
    assign imm8_s   = {{(WIDTH-IMM8_W){Instruction[IMM8_W-1]}}, Instruction[IMM8_W-1:0]};
    assign disp11_s = {{(WIDTH-DISP11_W){Instruction[DISP11_W-1]}}, Instruction[DISP11_W-1:0]};

    always_comb begin
        case (ALUSrc_cntrl)
            SRC_REG:  op_b = Read2data;
            SRC_IMM5: op_b = imm5_s;
            default:  op_b = imm8_s;
        endcase
    end

    alu #(.WIDTH(WIDTH)) u_alu (
        .a(Read1data), .b(op_b), .op(ALUOp_cntrl),
        .inv_a(ALU_InvA), .inv_b(ALU_InvB), .cin(ALU_Cin), .r(alu_r)
    );

    always_comb begin
        br_cond = 1'b0;
        case (Instruction[15:11])
            OP_BEQZ: br_cond = (alu_r == '0);
            OP_BNEZ: br_cond = (alu_r != '0);
            OP_BLTZ: br_cond = alu_r[WIDTH-1];
            OP_BGTZ: br_cond = ~alu_r[WIDTH-1];
            default: br_cond = 1'b0;
        endcase
    end

    assign br_taken  = Branch_cntrl & br_cond;
    assign ctl_taken = Jump_cntrl | br_taken;
    assign pc_next   = Jump_cntrl ? PC_Inc + disp11_s
                     : br_taken   ? PC_Inc + imm8_s
                     : PC_Inc;

    assign is_mul      = MUL_EN && Mul_cntrl;
    assign out_free    = ~out_valid | out_ready;
    assign accept      = in_valid & in_ready & ~flush_in;
    assign load_single = accept & ~is_mul;
    assign mul_start   = accept & is_mul;

    mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk(clk), .start(mul_start), .step(mul_step),
        .a(Read1data), .b(op_b), .done(mul_done), .product(mul_prod)
    );

    always_ff @(posedge clk) begin
        if (mul_start) mul_pc_p0 <= PC_Inc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (flush_in) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE:    if (mul_start) state_nx = MUL;
                MUL:     if (mul_done)  state_nx = DONE;
                DONE:    if (out_free)  state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready = (state == IDLE) & out_free;
        mul_step = (state == MUL);
        load_mul = (state == DONE) & out_free & ~flush_in;
    end

    // EX/MEM boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            ALU_Out     <= '0;
            PC_Next     <= '0;
            redirect    <= 1'b0;
            redirect_pc <= '0;
        end else begin
            redirect <= 1'b0;
            if (load_single) begin
                ALU_Out   <= alu_r;
                PC_Next   <= pc_next;
                out_valid <= 1'b1;
                if (ctl_taken) begin
                    redirect    <= 1'b1;
                    redirect_pc <= pc_next;
                end
            end else if (load_mul) begin
                ALU_Out   <= mul_prod;
                PC_Next   <= mul_pc_p0;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_execute_pipe.sv
// Scoreboard bench for execute_pipe: WIDTH=16 main instance plus a WIDTH=32 instance.
module tb_execute_pipe;
    import exec_pkg::*;

    localparam int W = 16;

    logic clk, rst_n, flush_in, out_ready;
    logic in_valid, in_ready, out_valid, redirect;
    logic [15:0] Instruction;
    logic [W-1:0] Read1data, Read2data, PC_Inc, ALU_Out, PC_Next, redirect_pc;
    logic [1:0] ALUSrc_cntrl;
    logic [3:0] ALUOp_cntrl;
    logic ALU_InvA, ALU_InvB, ALU_Cin, Branch_cntrl, Jump_cntrl, Mul_cntrl;

    logic in_valid32, in_ready32, out_valid32, redirect32;
    logic [31:0] r1_32, r2_32, pc_32, alu_32, pcn_32, rpc_32;

    typedef struct packed {
        logic [W-1:0] alu;
        logic [W-1:0] pc;
    } exp_t;

    exp_t         sb_q[$];
    logic [W-1:0] redir_q[$];
    int           n_cmp = 0;
    int           n_err = 0;

    execute_pipe #(.WIDTH(W), .MUL_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .flush_in(flush_in), .Instruction(Instruction), .Read1data(Read1data),
        .Read2data(Read2data), .PC_Inc(PC_Inc), .ALUSrc_cntrl(ALUSrc_cntrl),
        .ALUOp_cntrl(ALUOp_cntrl), .ALU_InvA(ALU_InvA), .ALU_InvB(ALU_InvB),
        .ALU_Cin(ALU_Cin), .Branch_cntrl(Branch_cntrl), .Jump_cntrl(Jump_cntrl),
        .Mul_cntrl(Mul_cntrl), .out_valid(out_valid), .out_ready(out_ready),
        .ALU_Out(ALU_Out), .PC_Next(PC_Next), .redirect(redirect),
        .redirect_pc(redirect_pc)
    );

    execute_pipe #(.WIDTH(32), .MUL_EN(1'b1)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid32), .in_ready(in_ready32),
        .flush_in(flush_in), .Instruction(Instruction), .Read1data(r1_32),
        .Read2data(r2_32), .PC_Inc(pc_32), .ALUSrc_cntrl(ALUSrc_cntrl),
        .ALUOp_cntrl(ALUOp_cntrl), .ALU_InvA(ALU_InvA), .ALU_InvB(ALU_InvB),
        .ALU_Cin(ALU_Cin), .Branch_cntrl(Branch_cntrl), .Jump_cntrl(Jump_cntrl),
        .Mul_cntrl(Mul_cntrl), .out_valid(out_valid32), .out_ready(out_ready),
        .ALU_Out(alu_32), .PC_Next(pcn_32), .redirect(redirect32),
        .redirect_pc(rpc_32)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Output monitor: every handshake must match the oldest expected result
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    check_eq("unexpected_result", out_valid, 1'b0);
                end else begin
                    e = sb_q.pop_front();
                    check_eq("alu_out", ALU_Out, e.alu);
                    check_eq("pc_next", PC_Next, e.pc);
                end
            end
            if (redirect) begin
                check_eq("redir_with_valid", out_valid, 1'b1);
                if (redir_q.size() == 0) check_eq("unexpected_redirect", redirect, 1'b0);
                else check_eq("redirect_pc", redirect_pc, redir_q.pop_front());
            end
        end
    end

    task automatic drive(input logic [15:0] instr, input logic [W-1:0] r1, r2, pc,
                         input logic [1:0] src, input logic [3:0] op,
                         input logic [2:0] mods, input logic [2:0] ctl);
        Instruction  = instr;
        Read1data    = r1;
        Read2data    = r2;
        PC_Inc       = pc;
        ALUSrc_cntrl = src;
        ALUOp_cntrl  = op;
        {ALU_InvA, ALU_InvB, ALU_Cin}          = mods;
        {Branch_cntrl, Jump_cntrl, Mul_cntrl} = ctl;
    endtask

    task automatic send(input bit push, input logic [W-1:0] e_alu, e_pc,
                        input bit rd, input logic [W-1:0] rpc, output int waited);
        exp_t e;
        in_valid = 1'b1;
        waited   = 0;
        @(negedge clk);
        while (!in_ready && waited < 200) begin
            waited++;
            @(negedge clk);
        end
        if (!in_ready) begin
            check_eq("accept_timeout", in_ready, 1'b1);
        end else begin
            @(posedge clk);
            #1;
            e.alu = e_alu;
            e.pc  = e_pc;
            if (push) sb_q.push_back(e);
            if (rd) redir_q.push_back(rpc);
        end
        in_valid = 1'b0;
    endtask

    initial begin
        int w;
        int seen;
        rst_n = 1'b0; in_valid = 1'b0; in_valid32 = 1'b0; flush_in = 1'b0; out_ready = 1'b1;
        r1_32 = '0; r2_32 = '0; pc_32 = '0;
        drive(16'h0000, '0, '0, '0, SRC_REG, ALU_ADD, 3'b000, 3'b000);
        #2;
        check_eq("rst_out_valid", out_valid, 1'b0);
        check_eq("rst_alu_out", ALU_Out, 16'h0000);
        check_eq("rst_in_ready", in_ready, 1'b1);
        check_eq("rst_redirect", redirect, 1'b0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk) #1;

        // ADD with one-cycle latency
        drive(16'h0000, 16'h0005, 16'h0003, 16'h0102, SRC_REG, ALU_ADD, 3'b000, 3'b000);
        send(1, 16'h0008, 16'h0102, 0, '0, w);
        @(negedge clk);
        check_eq("add_lat1_valid", out_valid, 1'b1);
        check_eq("add_no_redirect", redirect, 1'b0);
        @(posedge clk) #1;
        // SUB via InvB + Cin, imm5 sign-extended, XORI zero-extended, imm8
        drive(16'h0000, 16'h0005, 16'h0003, 16'h0104, SRC_REG, ALU_ADD, 3'b011, 3'b000);
        send(1, 16'h0002, 16'h0104, 0, '0, w);
        drive(16'h101E, 16'h0005, 16'h0000, 16'h0106, SRC_IMM5, ALU_ADD, 3'b000, 3'b000);
        send(1, 16'h0003, 16'h0106, 0, '0, w);
        drive(16'h501F, 16'h00F0, 16'h0000, 16'h0108, SRC_IMM5, ALU_XOR, 3'b000, 3'b000);
        send(1, 16'h00EF, 16'h0108, 0, '0, w);
        drive(16'h0080, 16'h0100, 16'h0000, 16'h010A, 2'b10, ALU_ADD, 3'b000, 3'b000);
        send(1, 16'h0080, 16'h010A, 0, '0, w);
        // Branches and jump
        drive(16'h60FC, 16'h0000, 16'h0000, 16'h0010, SRC_REG, ALU_PASSA, 3'b000, 3'b100);
        send(1, 16'h0000, 16'h000C, 1, 16'h000C, w);
        drive(16'h60FC, 16'h0001, 16'h0000, 16'h0010, SRC_REG, ALU_PASSA, 3'b000, 3'b100);
        send(1, 16'h0001, 16'h0010, 0, '0, w);
        drive(16'h7004, 16'h8000, 16'h0000, 16'h0030, SRC_REG, ALU_PASSA, 3'b000, 3'b100);
        send(1, 16'h8000, 16'h0034, 1, 16'h0034, w);
        drive(16'h07FE, 16'h0000, 16'h0000, 16'h0020, SRC_REG, ALU_ADD, 3'b000, 3'b010);
        send(1, 16'h0000, 16'h001E, 1, 16'h001E, w);

        // Multiply then a back-to-back ADD
        drive(16'h0000, 16'h0007, 16'hFFFD, 16'h0040, SRC_REG, ALU_ADD, 3'b000, 3'b001);
        send(1, 16'hFFEB, 16'h0040, 0, '0, w);
        drive(16'h0000, 16'h0100, 16'h0023, 16'h0042, SRC_REG, ALU_ADD, 3'b000, 3'b000);
        send(1, 16'h0123, 16'h0042, 0, '0, w);
        check_eq("mul_stall_cycles", w, 17);
        repeat (3) @(posedge clk);
        #1;

        // Back-pressure: first result held, upstream stalled
        out_ready = 1'b0;
        drive(16'h0000, 16'h1111, 16'h0001, 16'h0200, SRC_REG, ALU_ADD, 3'b000, 3'b000);
        send(1, 16'h1112, 16'h0200, 0, '0, w);
        drive(16'h0000, 16'h2222, 16'h0002, 16'h0202, SRC_REG, ALU_ADD, 3'b000, 3'b000);
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("bp_in_ready", in_ready, 1'b0);
            check_eq("bp_held_alu", ALU_Out, 16'h1112);
            check_eq("bp_held_valid", out_valid, 1'b1);
        end
        @(posedge clk) #1;
        out_ready = 1'b1;
        send(1, 16'h2224, 16'h0202, 0, '0, w);
        drive(16'h0000, 16'h3333, 16'h0003, 16'h0204, SRC_REG, ALU_ADD, 3'b000, 3'b000);
        send(1, 16'h3336, 16'h0204, 0, '0, w);
        repeat (3) @(posedge clk);
        #1;
        check_eq("bp_drained", sb_q.size(), 0);

        // Flush mid-multiply
        drive(16'h0000, 16'h0009, 16'h0009, 16'h0300, SRC_REG, ALU_ADD, 3'b000, 3'b001);
        send(0, '0, '0, 0, '0, w);
        repeat (4) @(posedge clk);
        #1;
        check_eq("mul_busy_in_ready", in_ready, 1'b0);
        flush_in = 1'b1;
        @(posedge clk) #1;
        flush_in = 1'b0;
        @(negedge clk);
        check_eq("flush_in_ready", in_ready, 1'b1);
        check_eq("flush_out_valid", out_valid, 1'b0);
        seen = 0;
        repeat (25) @(negedge clk) seen += int'(out_valid);
        check_eq("flush_no_result", seen, 0);
        @(posedge clk) #1;

        // Asynchronous reset mid-multiply
        drive(16'h0000, 16'h0005, 16'h0006, 16'h0400, SRC_REG, ALU_ADD, 3'b000, 3'b001);
        send(0, '0, '0, 0, '0, w);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check_eq("arst_out_valid", out_valid, 1'b0);
        check_eq("arst_alu_out", ALU_Out, 16'h0000);
        check_eq("arst_pc_next", PC_Next, 16'h0000);
        check_eq("arst_redirect", redirect, 1'b0);
        check_eq("arst_redirect_pc", redirect_pc, 16'h0000);
        check_eq("arst_in_ready", in_ready, 1'b1);
        @(negedge clk) rst_n = 1'b1;
        seen = 0;
        repeat (25) @(negedge clk) seen += int'(out_valid);
        check_eq("arst_no_result", seen, 0);
        @(posedge clk) #1;
        drive(16'h0000, 16'h0040, 16'h0004, 16'h0500, SRC_REG, ALU_SLL, 3'b000, 3'b000);
        send(1, 16'h0400, 16'h0500, 0, '0, w);

        // WIDTH=32 instance: ANDNI zero-extension, long jump
        drive(16'h501F, '0, '0, '0, SRC_IMM5, ALU_AND, 3'b010, 3'b000);
        r1_32 = 32'hFFFF_FFFF; pc_32 = 32'h0000_2000;
        in_valid32 = 1'b1;
        @(negedge clk) check_eq("w32_in_ready", in_ready32, 1'b1);
        @(posedge clk) #1 in_valid32 = 1'b0;
        @(negedge clk);
        check_eq("w32_andni_valid", out_valid32, 1'b1);
        check_eq("w32_andni_alu", alu_32, 32'hFFFF_FFE0);
        check_eq("w32_andni_pc", pcn_32, 32'h0000_2000);
        @(posedge clk) #1;
        drive(16'h0400, '0, '0, '0, SRC_REG, ALU_ADD, 3'b000, 3'b010);
        r1_32 = '0; pc_32 = 32'h0000_1000;
        in_valid32 = 1'b1;
        @(posedge clk) #1 in_valid32 = 1'b0;
        @(negedge clk);
        check_eq("w32_jmp_redirect", redirect32, 1'b1);
        check_eq("w32_jmp_target", rpc_32, 32'h0000_0C00);
        check_eq("w32_jmp_pc_next", pcn_32, 32'h0000_0C00);

        repeat (4) @(negedge clk);
        check_eq("sb_empty", sb_q.size(), 0);
        check_eq("redir_empty", redir_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
